// File: rtl/uart_cmd_ctrl.sv
`timescale 1ns/1ps
// Command frame parser and timed sequencer sitting between the UART byte stream
// and the LED/buzzer driver; every completed frame is answered with ACK or NAK.
module uart_cmd_ctrl #(
  parameter int TICK_CYC = 5_000_000,
  parameter int GAP_CYC  = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_vld,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_req,
  output logic [1:0] cmd,
  output logic       active
);

  localparam int TW = $clog2(TICK_CYC);
  localparam int GW = $clog2(GAP_CYC + 1);

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [1:0] {IDLE, GET_CMD, GET_DUR, GET_SUM} state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_byte_q, cmd_byte_d;
  logic [7:0]    dur_q, dur_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    unit_q, unit_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          active_q, active_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_req_q, tx_req_d;
  logic          pend_q, pend_d;

  logic          frame_done;
  logic          frame_good;
  logic          gap_timeout;
  logic [7:0]    sum_calc;

  assign sum_calc    = cmd_byte_q + dur_q;
  assign gap_timeout = (state_q != IDLE) && (gap_q == GW'(GAP_CYC));

  // Parser: a timed-out frame falls back to IDLE and the current byte is judged as an IDLE byte.
  always_comb begin
    state_d    = state_q;
    cmd_byte_d = cmd_byte_q;
    dur_d      = dur_q;
    gap_d      = gap_q;
    frame_done = 1'b0;
    frame_good = 1'b0;
    if (state_q == IDLE || gap_timeout) begin
      gap_d   = '0;
      state_d = (rx_vld && rx_data == HDR_BYTE) ? GET_CMD : IDLE;
    end else begin
      gap_d = rx_vld ? '0 : gap_q + GW'(1);
      case (state_q)
        GET_CMD: if (rx_vld) begin
          cmd_byte_d = rx_data;
          state_d    = GET_DUR;
        end
        GET_DUR: if (rx_vld) begin
          dur_d   = rx_data;
          state_d = GET_SUM;
        end
        GET_SUM: if (rx_vld) begin
          frame_done = 1'b1;
          frame_good = (rx_data == sum_calc) && (cmd_byte_q[7:2] == 6'd0);
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Duration timer; a good frame has priority over an expiry in the same cycle.
  always_comb begin
    cmd_d    = cmd_q;
    active_d = active_q;
    tick_d   = tick_q;
    unit_d   = unit_q;
    if (unit_q != 8'd0) begin
      if (tick_q == TW'(TICK_CYC - 1)) begin
        tick_d = '0;
        unit_d = unit_q - 8'd1;
        if (unit_q == 8'd1) begin
          cmd_d    = 2'b00;
          active_d = 1'b0;
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
    if (frame_good) begin
      cmd_d    = cmd_byte_q[1:0];
      active_d = |cmd_byte_q[1:0];
      tick_d   = '0;
      unit_d   = dur_q;
    end
  end

  // Single-entry response slot: a newer ACK/NAK overwrites an unsent one.
  always_comb begin
    tx_data_d = tx_data_q;
    pend_d    = pend_q;
    if (frame_done) begin
      tx_data_d = frame_good ? ACK_BYTE : NAK_BYTE;
      pend_d    = 1'b1;
    end
    tx_req_d = pend_d && !tx_busy;
    if (tx_req_d) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_byte_q <= 8'h00;
      dur_q      <= 8'h00;
      gap_q      <= '0;
      tick_q     <= '0;
      unit_q     <= 8'h00;
      cmd_q      <= 2'b00;
      active_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_req_q   <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_byte_q <= cmd_byte_d;
      dur_q      <= dur_d;
      gap_q      <= gap_d;
      tick_q     <= tick_d;
      unit_q     <= unit_d;
      cmd_q      <= cmd_d;
      active_q   <= active_d;
      tx_data_q  <= tx_data_d;
      tx_req_q   <= tx_req_d;
      pend_q     <= pend_d;
    end
  end

  assign tx_data = tx_data_q;
  assign tx_req  = tx_req_q;
  assign cmd     = cmd_q;
  assign active  = active_q;

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Frame parser and sequencer between the UART receiver/transmitter and the LED/buzzer driver. Collects a 4-byte command frame from the RX byte stream and validates it. On a good frame it drives the 2-bit driver command for a programmed duration, then returns the driver to idle. Every completed frame is acknowledged (ACK/NAK) through the UART transmitter handshake.

## Interface
- TICK_CYC, 5_000_000, clock cycles per duration unit (100 ms at 50 MHz); ≥ 2
- GAP_CYC, 500_000, max idle cycles between bytes of one frame before the frame is abandoned; ≥ 2
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte, valid when rx_vld = 1
- rx_vld  in  1  one-cycle strobe per received byte
- tx_busy  in  1  transmitter busy; tx_req is ignored by the transmitter while high
- tx_data  out  8  byte to transmit, stable while tx_req = 1
- tx_req  out  1  one-cycle transmit request
- cmd  out  2  driver command (bit0 = LEDs on, bit1 = buzzer on)
- active  out  1  high while a timed or latched command other than idle is being applied

## Operation
- Frame format, in order: header 0xA5, CMD, DUR, SUM.
  - SUM = (CMD + DUR) mod 256.
  - CMD[7:2] must be 0.
  - DUR = duration in TICK_CYC units, 1..255. DUR = 0 latches the command until the next good frame.
- Parser FSM states: IDLE → GET_CMD → GET_DUR → GET_SUM → IDLE.
  - IDLE: a byte ≠ 0xA5 is discarded silently. 0xA5 → GET_CMD.
  - GET_CMD / GET_DUR: each rx_vld stores the byte and advances the state.
  - GET_SUM: on rx_vld, the frame is good if SUM matches and CMD[7:2] = 0. Either way, return to IDLE.
  - Gap timeout: in GET_CMD, GET_DUR or GET_SUM, a gap counter clears on each rx_vld and increments otherwise. When it reaches GAP_CYC, return to IDLE with no ACK/NAK. The gap counter is held at 0 in IDLE.
- Good frame:
  - cmd ← CMD[1:0].
  - The tick counter and unit counter load with 0 and DUR. Any running command is replaced and its timer restarted.
  - active ← 1 if CMD[1:0] ≠ 0, else 0.
  - Queue ACK byte 0x06.
- Bad frame: cmd and timer are unchanged. Queue NAK byte 0x15.
- Timer (applies only when DUR ≠ 0):
  - The tick counter counts 0..TICK_CYC-1. At each wrap the unit counter decrements.
  - When the unit counter reaches 0: cmd ← 2'b00 and active ← 0, in the same cycle.
  - With DUR = 0 the timer is idle.
- Transmit:
  - A queued byte sets pend = 1 and latches tx_data.
  - When pend = 1 and tx_busy = 0: tx_req = 1 for exactly one cycle, then pend clears.
  - A new ACK/NAK queued while pend = 1 overwrites tx_data; only one request is issued.
  - tx_data holds its last value after the request.

## Timing
- Reset values: cmd = 2'b00, active = 0, tx_req = 0, tx_data = 8'h00. FSM in IDLE, all counters 0, pend = 0.
- Reset asserted mid-frame or mid-command: everything returns to reset values immediately. No ACK is sent after release.
- cmd and active update on the clock edge following the cycle in which the SUM byte has rx_vld = 1 (latency 1).
- tx_req latency from the SUM byte strobe: 1 cycle if tx_busy = 0 at that edge; otherwise the first cycle after tx_busy is sampled low.
- Timed duration: cmd returns to 00 exactly DUR × TICK_CYC cycles after cmd is loaded.
- A good frame completing in the same cycle as timer expiry: the new frame wins. cmd takes the new CMD and the timer reloads.
- Gap timeout: with rx_vld absent for GAP_CYC consecutive cycles after a strobe, the FSM is in IDLE on the next edge. A byte arriving in the cycle the timeout fires is treated as an IDLE byte.
- Counter widths: tick counter $clog2(TICK_CYC), unit counter 8 bits, gap counter $clog2(GAP_CYC+1). Counters never wrap past their terminal value.

## Test plan
- Use TICK_CYC = 10, GAP_CYC = 20 throughout.
- Good timed frame: send A5 01 03 04 with tx_busy = 0 → cmd = 01 and active = 1 one cycle after the SUM strobe; tx_req pulses with tx_data = 0x06; cmd = 00 and active = 0 exactly 30 cycles after load.
- Bad checksum and illegal CMD:
  - A5 02 05 00 → NAK 0x15; cmd unchanged.
  - A5 04 00 04 → NAK 0x15; cmd unchanged.
  - Stray bytes 0x11 0x22 in IDLE → no tx_req.
- Latched command and replacement: A5 03 00 03 → cmd = 11 held for ≥ 200 cycles. Then A5 02 02 04 → cmd = 10; it reverts to 00 after 20 cycles.
- Gap timeout: A5 01, then 21 idle cycles, then 03 04 → no ACK and cmd stays 00. A following full frame A5 01 01 02 → ACK and cmd = 01.
- Busy transmitter: hold tx_busy = 1 and send two frames (A5 01 01 02, then A5 07 00 07) → no tx_req while busy. After release, exactly one tx_req with tx_data = 0x15.
- Reset mid-command: during a 5-unit command, assert rst_n low for 3 cycles → cmd = 00, active = 0, tx_req = 0 during and after release; the next frame is parsed normally.
